// File: rtl/seq_pkg.sv
// Shared types and constants for the multicycle sequencer: phase encoding,
// control-word bit positions and the opcode -> control word decode table.
package seq_pkg;

    localparam int unsigned SEQ_OPC_W   = 4;
    localparam int unsigned SEQ_CW_W    = 8;
    localparam int unsigned CW_HALT_BIT = 7;
    localparam int unsigned CW_WE_BIT   = 6;
    localparam int unsigned CW_MEM_BIT  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [SEQ_CW_W-1:0] CW_NOP  = 8'h40;
    localparam logic [SEQ_CW_W-1:0] CW_OP1  = 8'h61;
    localparam logic [SEQ_CW_W-1:0] CW_LDST = 8'h50;
    localparam logic [SEQ_CW_W-1:0] CW_OP3  = 8'h63;
    localparam logic [SEQ_CW_W-1:0] CW_OP5  = 8'h65;
    localparam logic [SEQ_CW_W-1:0] CW_OP7  = 8'h67;
    localparam logic [SEQ_CW_W-1:0] CW_OP9  = 8'h69;
    localparam logic [SEQ_CW_W-1:0] CW_OP11 = 8'h6B;
    localparam logic [SEQ_CW_W-1:0] CW_OP12 = 8'h6D;
    localparam logic [SEQ_CW_W-1:0] CW_HALT = 8'hC0;

    // Unlisted opcodes decode to a no-op that still writes back.
    function automatic logic [SEQ_CW_W-1:0] cw_lookup(input logic [SEQ_OPC_W-1:0] opc);
        logic [SEQ_CW_W-1:0] cw;
        case (opc)
            4'd1:    cw = CW_OP1;
            4'd2:    cw = CW_LDST;
            4'd3:    cw = CW_OP3;
            4'd5:    cw = CW_OP5;
            4'd7:    cw = CW_OP7;
            4'd9:    cw = CW_OP9;
            4'd11:   cw = CW_OP11;
            4'd12:   cw = CW_OP12;
            4'd15:   cw = CW_HALT;
            default: cw = CW_NOP;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory-port handshake and datapath control bundle between the sequencer
// (master) and the datapath/memory side (slave).
interface multicycle_sequencer_if
    import seq_pkg::*;
#(
    parameter int unsigned OPC_W = SEQ_OPC_W,
    parameter int unsigned CW_W  = SEQ_CW_W
) ();

    logic             mem_req;
    logic             mem_ready;
    logic [OPC_W-1:0] opcode;
    logic             ir_load;
    logic             pc_inc;
    logic [CW_W-1:0]  cw;
    logic             cw_valid;
    logic             reg_we;

    modport master (
        output mem_req, ir_load, pc_inc, cw, cw_valid, reg_we,
        input  mem_ready, opcode
    );

    modport slave (
        input  mem_req, ir_load, pc_inc, cw, cw_valid, reg_we,
        output mem_ready, opcode
    );

endinterface

// File: rtl/seq_wait_timer.sv
// Counts consecutive cycles a memory request goes unanswered and flags the
// cycle in which the MEM_TIMEOUT-th unanswered cycle occurs.
module seq_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = enable && (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer with memory timeout.
// Define SEQ_PERF_CNT_EN to add the retired/stall_cycles performance counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned OPC_W       = SEQ_OPC_W,
    parameter int unsigned CW_W        = SEQ_CW_W,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    multicycle_sequencer_if.master bus,
    output logic                   halted,
    output logic                   fault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]            retired,
    output logic [15:0]            stall_cycles
`endif
);

    state_e           state;
    state_e           state_next;
    logic             waiting;
    logic             expired_c;
    logic [OPC_W-1:0] opc;

    assign opc     = bus.opcode;
    assign waiting = (state == S_FETCH) || (state == S_MEM);

    seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!waiting || bus.mem_ready),
        .enable   (waiting && !bus.mem_ready),
        .expired_c(expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase strobes are suppressed for the whole reset cycle so an aborted
    // fetch or writeback never leaks a pulse into the datapath.
    always_comb begin
        state_next   = state;
        bus.mem_req  = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.cw_valid = 1'b0;
        bus.reg_we   = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (start) state_next = S_FETCH;
                end
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_load = 1'b1;
                        bus.pc_inc  = 1'b1;
                        state_next  = S_DECODE;
                    end else if (expired_c) begin
                        state_next = S_HALT;
                    end
                end
                S_DECODE: begin
                    state_next = S_EXEC;
                end
                S_EXEC: begin
                    bus.cw_valid = 1'b1;
                    if (bus.cw[CW_HALT_BIT])     state_next = S_HALT;
                    else if (bus.cw[CW_MEM_BIT]) state_next = S_MEM;
                    else                         state_next = S_WB;
                end
                S_MEM: begin
                    bus.cw_valid = 1'b1;
                    bus.mem_req  = 1'b1;
                    if (bus.mem_ready)  state_next = S_WB;
                    else if (expired_c) state_next = S_HALT;
                end
                S_WB: begin
                    bus.cw_valid = 1'b1;
                    bus.reg_we   = bus.cw[CW_WE_BIT];
                    state_next   = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Control word only changes on the DECODE edge and holds until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cw <= '0;
        end else if (state == S_DECODE) begin
            bus.cw <= CW_W'(cw_lookup(SEQ_OPC_W'(opc)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (expired_c) begin
            fault <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Saturating counters: instructions leaving WB, and unanswered request cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired      <= 16'd0;
            stall_cycles <= 16'd0;
        end else begin
            if ((state == S_WB) && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end
            if (waiting && !bus.mem_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
